btn_event: RTL and testbench
============================

# btn_event

Per-button input conditioner for the lab board: synchronises a raw push-button, debounces it, and turns it into clean single-cycle event pulses with hold-to-repeat. One instance per `usr_btn` bit sits directly upstream of the counter/brightness update logic. Its `press` output is a drop-in one-cycle step strobe. Holding a button auto-steps the value instead of requiring repeated presses.

## Interface
- `DEBOUNCE_CYC`, default 1000000: consecutive cycles of disagreement needed before the debounced level flips. Must be ≥1.
- `HOLD_CYC`, default 50000000: cycles from the first `press` to the first repeat/long event. Must be ≥2.
- `REPEAT_CYC`, default 10000000: cycles between successive repeat `press` pulses. Must be ≥2.
- `clk`, input, 1: single system clock, rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_in`, input, 1: raw button, asynchronous to `clk`, active high.
- `press`, output, 1: one-cycle pulse on the debounced press and on every auto-repeat.
- `release`, output, 1: one-cycle pulse on the debounced release.
- `long_press`, output, 1: one-cycle pulse when the hold time first expires. Fires once per press.
- `level`, output, 1: debounced button level.

## Operation
- **Synchroniser:** 2-flop chain `btn_in` → `s1` → `s2`. Only `s2` is used downstream.
- **Debounce:**
  - Counter width is `$clog2(DEBOUNCE_CYC+1)`.
  - If `s2 == stable`, the counter clears to 0.
  - Otherwise, if counter == `DEBOUNCE_CYC-1`, `stable <= s2` and the counter clears.
  - Otherwise the counter increments.
  - `level = stable`.
- **Event FSM**, states IDLE, HOLD, REPEAT; hold/repeat counter width is `$clog2(max(HOLD_CYC,REPEAT_CYC))`:
  - **IDLE:** on `stable` rising, `press` is set next cycle, the counter clears, and the FSM goes to HOLD.
  - **HOLD:** on `stable` falling, `release` is set and the FSM goes to IDLE. When counter == `HOLD_CYC-1`, `press` and `long_press` are set, the counter clears, and the FSM goes to REPEAT. Otherwise the counter increments.
  - **REPEAT:** on `stable` falling, `release` is set and the FSM goes to IDLE. When counter == `REPEAT_CYC-1`, `press` is set and the counter clears. Otherwise the counter increments.
- All outputs are registered; each pulse lasts exactly one cycle.
- **Simultaneous events:** a falling `stable` in the same cycle as a hold/repeat expiry means release wins. Only `release` fires; no `press` or `long_press`.
- `press` and `release` are never high in the same cycle.
- `stable` can change at most once per `DEBOUNCE_CYC` cycles, so a glitch shorter than `DEBOUNCE_CYC` cycles after synchronisation produces no event.

## Timing
- **Reset values:**
  - `s1`, `s2`, `stable`, and both counters are 0, and the FSM is in IDLE.
  - `press`, `release`, `long_press`, `level` are all 0.
- **Press latency:** edge 0 is the first edge that samples `btn_in` high, with the input held.
  - `level` rises after edge `DEBOUNCE_CYC+1`.
  - `press` is high for the cycle after edge `DEBOUNCE_CYC+2`.
- **Release latency:** identical, on `release`.
- **First repeat:** the second `press` comes exactly `HOLD_CYC` cycles after the first `press`, coincident with `long_press`.
- **Later repeats:** each further `press` follows the previous one by exactly `REPEAT_CYC` cycles.
- **Reset mid-operation:** all state clears immediately, and no pulse is emitted on reset release.
  - If the button is held through reset, it is treated as a fresh press.
  - That press emits `press` `DEBOUNCE_CYC+2` edges after reset deassertion.
- **Counter rollover:** counters never wrap; they are always cleared at their terminal value.

## Configuration
- Macro: `BTN_EVENT_REPEAT_EN`.
- **Defined:** behaviour is as above. REPEAT emits periodic `press` pulses, and the hold expiry also emits a `press`.
- **Undefined:**
  - The REPEAT state still exists, but its counter is held at 0 and it emits no `press`.
  - Hold expiry emits only `long_press`, with no `press`.
  - Exactly one `press` is emitted per physical press.
  - `release` and `level` are unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYC=4`, `HOLD_CYC=20`, `REPEAT_CYC=8`, with the macro defined unless noted.

- **Clean tap:** `btn_in` high for 12 cycles then low. One `press` 6 edges after the rise, one `release` 6 edges after the fall, no `long_press`, `level` high for 12 cycles.
- **Bounce rejection:** 3-cycle high glitches separated by 1-cycle lows, for 40 cycles. No pulses, `level` stays 0.
- **Hold with repeat:** hold for 60 cycles after the first `press`. `press` at offsets 0, 20, 28, 36, 44, 52; `long_press` only at 20; one `release` after the fall.
- **Repeat disabled:** same stimulus with the macro undefined. `press` only at offset 0, `long_press` at 20, one `release`.
- **Release on hold expiry:** align so `stable` falls on the cycle the counter hits 19. `release` only, no `press` or `long_press`.
- **Reset mid-hold:** assert `reset_n` low at offset 10 while the button is held. All outputs drop to 0. After reset release, `press` arrives 6 edges later.

Source files
------------

// File: rtl/btn_event.sv
// Push-button conditioner: 2-flop sync, debounce, press/release/long/repeat pulses.
// `BTN_EVENT_REPEAT_EN enables auto-repeat presses; `release` is a reserved word, so that output is `released`.
module btn_event #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int HOLD_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic press,
  output logic released,
  output logic long_press,
  output logic level
);
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int MAXC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int CW   = $clog2(MAXC);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  logic          s1, s2, stable;
  logic [DW-1:0] db_cnt;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          press_nx, rel_nx, long_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
      if (s2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign level = stable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      press      <= press_nx;
      released   <= rel_nx;
      long_press <= long_nx;
    end
  end

  // A falling level always takes priority over a hold/repeat expiry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (stable) begin
        state_nx = HOLD;
        cnt_nx   = '0;
      end
      HOLD: if (!stable) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else if (cnt == HOLD_LAST) begin
        state_nx = REPEAT;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      REPEAT: if (!stable) begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end else begin
`ifdef BTN_EVENT_REPEAT_EN
        if (cnt == REP_LAST) cnt_nx = '0;
        else                 cnt_nx = cnt + 1'b1;
`else
        cnt_nx = '0;
`endif
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    press_nx = 1'b0;
    rel_nx   = 1'b0;
    long_nx  = 1'b0;
    case (state)
      IDLE: press_nx = stable;
      HOLD: if (!stable) begin
        rel_nx = 1'b1;
      end else if (cnt == HOLD_LAST) begin
        long_nx = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
        press_nx = 1'b1;
`endif
      end
      REPEAT: if (!stable) begin
        rel_nx = 1'b1;
      end else begin
`ifdef BTN_EVENT_REPEAT_EN
        press_nx = (cnt == REP_LAST);
`endif
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event (DEBOUNCE=4, HOLD=20, REPEAT=8); expectations follow the
// build's BTN_EVENT_REPEAT_EN setting.
module tb_btn_event;
  logic clk = 1'b0, reset_n = 1'b0, btn_in = 1'b0;
  logic press, released, long_press, level;
  int   cyc = 0, nvec = 0, nerr = 0, lvl_cnt = 0, ovl = 0;
  int   press_q[$], rel_q[$], long_q[$];

  btn_event #(.DEBOUNCE_CYC(4), .HOLD_CYC(20), .REPEAT_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
    .press(press), .released(released), .long_press(long_press), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (reset_n) begin
    if (press)      press_q.push_back(cyc);
    if (released)   rel_q.push_back(cyc);
    if (long_press) long_q.push_back(cyc);
    if (level)      lvl_cnt++;
    if (press && released) ovl++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    press_q.delete(); rel_q.delete(); long_q.delete(); lvl_cnt = 0;
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int r, p, f, c;
    int exp_p[$];

    tick(3);
    chk("rst press", int'(press), 0);
    chk("rst release", int'(released), 0);
    chk("rst long", int'(long_press), 0);
    chk("rst level", int'(level), 0);
    reset_n = 1'b1;
    tick(3);

    // clean tap
    clr(); btn_in = 1'b1; r = cyc + 1;
    tick(12); btn_in = 1'b0; f = cyc + 1;
    tick(20);
    chk("tap press n", press_q.size(), 1);
    chk("tap press t", at(press_q, 0), r + 6);
    chk("tap rel n", rel_q.size(), 1);
    chk("tap rel t", at(rel_q, 0), f + 6);
    chk("tap long n", long_q.size(), 0);
    chk("tap level cyc", lvl_cnt, 12);

    // bounce: 3 high / 1 low never survives the debounce window
    clr();
    for (int i = 0; i < 10; i++) begin
      btn_in = 1'b1; tick(3);
      btn_in = 1'b0; tick(1);
    end
    tick(12);
    chk("bnc press n", press_q.size(), 0);
    chk("bnc rel n", rel_q.size(), 0);
    chk("bnc long n", long_q.size(), 0);
    chk("bnc level cyc", lvl_cnt, 0);

    // long hold: release timed so the release lands at p+56, before the p+60 repeat
    clr(); btn_in = 1'b1; r = cyc + 1; p = r + 6;
    tick(p + 50 - (cyc + 1)); btn_in = 1'b0;
    tick(20);
`ifdef BTN_EVENT_REPEAT_EN
    exp_p = '{p, p + 20, p + 28, p + 36, p + 44, p + 52};
`else
    exp_p = '{p};
`endif
    chk("hold press n", press_q.size(), exp_p.size());
    foreach (exp_p[i]) chk($sformatf("hold press[%0d]", i), at(press_q, i), exp_p[i]);
    chk("hold long n", long_q.size(), 1);
    chk("hold long t", at(long_q, 0), p + 20);
    chk("hold rel n", rel_q.size(), 1);
    chk("hold rel t", at(rel_q, 0), p + 56);

    // level falls exactly on hold expiry: release only
    clr(); btn_in = 1'b1; r = cyc + 1; p = r + 6;
    tick(20); btn_in = 1'b0;
    tick(20);
    chk("tie press n", press_q.size(), 1);
    chk("tie press t", at(press_q, 0), p);
    chk("tie long n", long_q.size(), 0);
    chk("tie rel n", rel_q.size(), 1);
    chk("tie rel t", at(rel_q, 0), p + 20);

    // reset mid-hold with the button still down
    clr(); btn_in = 1'b1; r = cyc + 1; p = r + 6;
    tick(p + 9 - cyc);
    chk("mid level pre", int'(level), 1);
    reset_n = 1'b0; #1;
    chk("mid rst press", int'(press), 0);
    chk("mid rst release", int'(released), 0);
    chk("mid rst long", int'(long_press), 0);
    chk("mid rst level", int'(level), 0);
    tick(3);
    clr(); reset_n = 1'b1; c = cyc;
    tick(15);
    chk("mid press n", press_q.size(), 1);
    chk("mid press t", at(press_q, 0), c + 7);
    chk("mid rel n", rel_q.size(), 0);
    chk("mid long n", long_q.size(), 0);
    btn_in = 1'b0;
    tick(15);
    chk("mid rel after", rel_q.size(), 1);

    chk("press+release overlap", ovl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
